// File: rtl/gray_async_counter_if.sv
// gray_async_counter_if: count outputs of the Gray counter (Gray code, binary value, terminal flag).
interface gray_async_counter_if #(
    parameter int DATA_WID = 4
);
    logic [DATA_WID-1:0] Count;
    logic [DATA_WID-1:0] Bin_Count;
    logic                Terminal;

    modport master (output Count, Bin_Count, Terminal);
    modport slave  (input  Count, Bin_Count, Terminal);
endinterface

// File: rtl/gray_async_counter.sv
// gray_async_counter: free-running up-counter with a registered Gray output, binary shadow and terminal flag.
module gray_async_counter #(
    parameter int DATA_WID = 4
) (
    input  logic                   clk,
    input  logic                   n_reset,
    gray_async_counter_if.master   bus
);
    logic [DATA_WID-1:0] next_bin;

    assign next_bin = bus.Bin_Count + DATA_WID'(1);

    // Gray and terminal are encoded from next_bin so every output is a plain flop (glitch-free for CDC).
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bus.Bin_Count <= '0;
            bus.Count     <= '0;
            bus.Terminal  <= 1'b0;
        end else begin
            bus.Bin_Count <= next_bin;
            bus.Count     <= next_bin ^ (next_bin >> 1);
            bus.Terminal  <= &next_bin;
        end
    end
endmodule

// File: tb/tb_gray_async_counter.sv
// tb_gray_async_counter: table-driven check of the 4-bit Gray sequence plus a 6-bit instance run through its wrap.
module tb_gray_async_counter;
    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    gray_async_counter_if #(.DATA_WID(4)) b4 ();
    gray_async_counter_if #(.DATA_WID(6)) b6 ();

    gray_async_counter #(.DATA_WID(4)) dut4 (.clk(clk), .n_reset(n_reset), .bus(b4.master));
    gray_async_counter #(.DATA_WID(6)) dut6 (.clk(clk), .n_reset(n_reset), .bus(b6.master));

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic       term;
    } vec_t;

    vec_t       tbl [16];
    logic [3:0] codes [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    int         tests = 0;
    int         fails = 0;
    int         k = 0;
    logic [5:0] bin6 = '0;
    logic [3:0] prev4 = '0;
    logic [5:0] prev6 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gray4"}, 32'(b4.Count), 0);
        chk({tag, "_bin4"}, 32'(b4.Bin_Count), 0);
        chk({tag, "_term4"}, 32'(b4.Terminal), 0);
        chk({tag, "_gray6"}, 32'(b6.Count), 0);
        chk({tag, "_bin6"}, 32'(b6.Bin_Count), 0);
        chk({tag, "_term6"}, 32'(b6.Terminal), 0);
    endtask

    task automatic step(input string tag);
        k = (k + 1) % 16;
        bin6 = bin6 + 6'd1;
        @(negedge clk);
        chk({tag, "_gray4"}, 32'(b4.Count), 32'(tbl[k].gray));
        chk({tag, "_bin4"}, 32'(b4.Bin_Count), 32'(tbl[k].bin));
        chk({tag, "_term4"}, 32'(b4.Terminal), 32'(tbl[k].term));
        chk({tag, "_onebit4"}, $countones(b4.Count ^ prev4), 1);
        chk({tag, "_gray6"}, 32'(b6.Count), 32'(bin6 ^ (bin6 >> 1)));
        chk({tag, "_bin6"}, 32'(b6.Bin_Count), 32'(bin6));
        chk({tag, "_term6"}, 32'(b6.Terminal), 32'(bin6 == 6'd63));
        chk({tag, "_onebit6"}, $countones(b6.Count ^ prev6), 1);
        if (bin6 == 6'd63) chk({tag, "_termcode6"}, 32'(b6.Count), 32'(6'b100000));
        prev4 = b4.Count;
        prev6 = b6.Count;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].gray = codes[i];
            tbl[i].bin  = 4'(i);
            tbl[i].term = (i == 15);
        end
        repeat (3) begin
            @(negedge clk);
            chk_zero("reset_hold");
        end
        // Release lands in the same time step as the edge, after the flops have sampled it low.
        @(posedge clk);
        n_reset <= 1'b1;
        @(negedge clk);
        chk_zero("release_edge");
        k = 0;
        bin6 = '0;
        prev4 = b4.Count;
        prev6 = b6.Count;
        repeat (17) step("cycle");
        repeat (3) step("pre_rst");
        chk("mid_count_gray4", 32'(b4.Count), 32'(4'b0110));
        #2 n_reset = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        chk_zero("async_rst_hold");
        n_reset = 1'b1;
        k = 0;
        bin6 = '0;
        prev4 = '0;
        prev6 = '0;
        step("restart");
        chk("restart_gray4", 32'(b4.Count), 32'(4'b0001));
        repeat (70) step("w6");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
